// File: rtl/sm4_key_sched_if.sv
// ---------------------------------------------------------------------------
// sm4_key_sched_if
//   Bundles the key-load, read-request and round-key stream signals of the
//   SM4 key-schedule engine.
//
//   master modport : the surrounding logic (key loader + round core)
//   slave  modport : the key-schedule engine
//
//   mk         [0:127] master key, bit 0 is MSB, MK0 = mk[0:31]
//   key_valid          master key offered
//   key_ready          engine can accept a key
//   keys_valid         buffer holds a complete, current schedule
//   rd_start           request one 32-key stream
//   rd_dir             0 forward (rk0 first), 1 reverse (rk31 first)
//   rk         [0:31]  streamed round key
//   rk_valid           rk is valid
//   rk_ready           consumer accepts rk
//   rk_last            marks the 32nd beat of a stream
// ---------------------------------------------------------------------------
interface sm4_key_sched_if;
  logic [0:127] mk;
  logic         key_valid;
  logic         key_ready;
  logic         keys_valid;
  logic         rd_start;
  logic         rd_dir;
  logic [0:31]  rk;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;

  modport master (
    output mk, key_valid, rd_start, rd_dir, rk_ready,
    input  key_ready, keys_valid, rk, rk_valid, rk_last
  );

  modport slave (
    input  mk, key_valid, rd_start, rd_dir, rk_ready,
    output key_ready, keys_valid, rk, rk_valid, rk_last
  );
endinterface

// File: rtl/sm4_key_sched.sv
// ---------------------------------------------------------------------------
// sm4_key_sched
//   Iterative SM4 key-schedule engine. Expands a 128-bit master key into the
//   32 round keys (one round per clock), stores them in a 32x32 buffer and
//   streams them to the round core, forward for encryption or reverse for
//   decryption.
//
//   Ports:
//     clk  : clock, all logic on the rising edge
//     rst  : synchronous, active-high reset
//     bus  : sm4_key_sched_if.slave (key load, read request, key stream)
//
//   Configuration macro: SM4_KEY_REV_EN
//     defined   : rd_dir = 1 streams rk31..rk0 with rk_last on rk0
//     undefined : rd_dir is ignored, every stream is rk0..rk31
// ---------------------------------------------------------------------------
module sm4_key_sched (
  input  logic           clk,
  input  logic           rst,
  sm4_key_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_READY,
    S_STREAM
  } state_e;

  localparam logic [0:3][31:0] FK = {
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  localparam logic [0:31][31:0] CK = {
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  localparam logic [0:255][7:0] SBOX = {
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

  // Key-schedule round transform: byte-wise S-box, then L'(B) = B ^ B<<<13 ^ B<<<23.
  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] b;
    b = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [31:0] k_q [4];
  logic [31:0] k_d [4];
  logic        key_ready_q, key_ready_d;
  logic        keys_valid_q, keys_valid_d;
  logic        rk_valid_q, rk_valid_d;
  logic        rk_last_q, rk_last_d;
  logic [31:0] rk_q, rk_d;

  logic [31:0] key_buf [32];
  logic        buf_we;
  logic [31:0] rk_new;
  logic        load_key;
  logic        start_rd;
  logic [4:0]  rd_first;
  logic [4:0]  ptr_step;
  logic [4:0]  ptr_end;

  // Key load wins over a same-cycle read request; both only act in IDLE/READY.
  assign load_key = bus.key_valid && (state_q == S_IDLE || state_q == S_READY);
  assign start_rd = bus.rd_start && !bus.key_valid && (state_q == S_READY);
  assign rk_new   = k_q[0] ^ t_prime(k_q[1] ^ k_q[2] ^ k_q[3] ^ CK[cnt_q]);

`ifdef SM4_KEY_REV_EN
  logic dir_q, dir_d;

  assign rd_first = bus.rd_dir ? 5'd31 : 5'd0;
  assign ptr_step = dir_q ? ptr_q - 5'd1 : ptr_q + 5'd1;
  assign ptr_end  = dir_q ? 5'd0 : 5'd31;
  assign dir_d    = start_rd ? bus.rd_dir : dir_q;

  always_ff @(posedge clk) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_d;
  end
`else
  assign rd_first = 5'd0;
  assign ptr_step = ptr_q + 5'd1;
  assign ptr_end  = 5'd31;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    key_ready_d  = key_ready_q;
    keys_valid_d = keys_valid_q;
    rk_valid_d   = rk_valid_q;
    rk_last_d    = rk_last_q;
    rk_d         = rk_q;
    buf_we       = 1'b0;
    for (int j = 0; j < 4; j++) k_d[j] = k_q[j];

    if (load_key) begin
      for (int j = 0; j < 4; j++) k_d[j] = bus.mk[32*j +: 32] ^ FK[j];
      cnt_d        = 5'd0;
      state_d      = S_EXPAND;
      key_ready_d  = 1'b0;
      keys_valid_d = 1'b0;
    end else if (start_rd) begin
      ptr_d       = rd_first;
      state_d     = S_STREAM;
      key_ready_d = 1'b0;
      rk_valid_d  = 1'b1;
      rk_d        = key_buf[rd_first];
      rk_last_d   = 1'b0;
    end else if (state_q == S_EXPAND) begin
      // Write rk_i and slide the four-word window by one.
      buf_we = 1'b1;
      k_d[0] = k_q[1];
      k_d[1] = k_q[2];
      k_d[2] = k_q[3];
      k_d[3] = rk_new;
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d      = S_READY;
        key_ready_d  = 1'b1;
        keys_valid_d = 1'b1;
      end
    end else if (state_q == S_STREAM && bus.rk_ready) begin
      // rk_valid is constant high in STREAM, so rk_ready alone marks a handshake.
      if (rk_last_q) begin
        state_d     = S_READY;
        key_ready_d = 1'b1;
        rk_valid_d  = 1'b0;
        rk_last_d   = 1'b0;
      end else begin
        ptr_d     = ptr_step;
        rk_d      = key_buf[ptr_step];
        rk_last_d = (ptr_step == ptr_end);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 5'd0;
      ptr_q        <= 5'd0;
      key_ready_q  <= 1'b1;
      keys_valid_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_last_q    <= 1'b0;
      rk_q         <= 32'd0;
      for (int j = 0; j < 4; j++) k_q[j] <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      key_ready_q  <= key_ready_d;
      keys_valid_q <= keys_valid_d;
      rk_valid_q   <= rk_valid_d;
      rk_last_q    <= rk_last_d;
      rk_q         <= rk_d;
      for (int j = 0; j < 4; j++) k_q[j] <= k_d[j];
    end
  end

  // NOTE: the key buffer is deliberately not reset; keys_valid guards its contents.
  always_ff @(posedge clk) begin
    if (buf_we) key_buf[cnt_q] <= rk_new;
  end

  assign bus.key_ready  = key_ready_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.rk_valid   = rk_valid_q;
  assign bus.rk_last    = rk_last_q;
  assign bus.rk         = rk_q;

endmodule

// File: tb/tb_sm4_key_sched.sv
// ---------------------------------------------------------------------------
// tb_sm4_key_sched
//   Self-checking bench for sm4_key_sched. A behavioural model computes the
//   full key schedule from the master key with plain arithmetic; streamed
//   keys, handshake timing, reset behaviour and ignored requests are checked
//   against it. Reverse-stream expectations follow SM4_KEY_REV_EN.
// ---------------------------------------------------------------------------
module tb_sm4_key_sched;

  logic clk = 1'b0;
  logic rst;

  sm4_key_sched_if bus_if ();

  sm4_key_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_rk [32];
  logic [31:0] first_rk;
  logic [31:0] last_rk;

  localparam logic [7:0] SBOX_T [256] = '{
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // CK_i byte j = (4i + j) * 7 mod 256
  function automatic logic [31:0] model_ck(input int i);
    logic [31:0] r = 32'd0;
    for (int j = 0; j < 4; j++) r = (r << 8) | 32'(((4 * i + j) * 7) % 256);
    return r;
  endfunction

  function automatic logic [31:0] model_tp(input logic [31:0] x);
    logic [31:0] b = 32'd0;
    for (int j = 0; j < 4; j++) begin
      int sh = 24 - 8 * j;
      int idx = int'((x >> sh) & 32'hFF);
      b = b | (32'(SBOX_T[idx]) << sh);
    end
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  task automatic model_schedule(input logic [0:127] key);
    logic [31:0] fk [4];
    logic [31:0] k [36];
    fk[0] = 32'hA3B1BAC6; fk[1] = 32'h56AA3350;
    fk[2] = 32'h677D9197; fk[3] = 32'hB27022DC;
    for (int j = 0; j < 4; j++) k[j] = key[32*j +: 32] ^ fk[j];
    for (int i = 0; i < 32; i++) begin
      k[i+4] = k[i] ^ model_tp(k[i+1] ^ k[i+2] ^ k[i+3] ^ model_ck(i));
      exp_rk[i] = k[i+4];
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic reset_values(input string tag);
    check({tag, " key_ready"},  32'(bus_if.key_ready),  32'd1);
    check({tag, " keys_valid"}, 32'(bus_if.keys_valid), 32'd0);
    check({tag, " rk_valid"},   32'(bus_if.rk_valid),   32'd0);
    check({tag, " rk_last"},    32'(bus_if.rk_last),    32'd0);
    check({tag, " rk"},         bus_if.rk,              32'd0);
  endtask

  // Offer a key (optionally with a same-cycle rd_start), optionally toggle
  // rd_start during expansion, and measure the accept-to-keys_valid latency.
  task automatic load_key(input logic [0:127] key, input bit rd_too, input bit rd_during,
                          input string tag);
    int cyc;
    bit saw_rk;
    model_schedule(key);
    @(negedge clk);
    check({tag, " ready before load"}, 32'(bus_if.key_ready), 32'd1);
    bus_if.mk        = key;
    bus_if.key_valid = 1'b1;
    bus_if.rd_start  = rd_too;
    bus_if.rd_dir    = 1'b0;
    @(negedge clk);
    bus_if.key_valid = 1'b0;
    bus_if.rd_start  = 1'b0;
    check({tag, " key_ready after accept"},  32'(bus_if.key_ready),  32'd0);
    check({tag, " keys_valid after accept"}, 32'(bus_if.keys_valid), 32'd0);
    cyc    = 1;
    saw_rk = bus_if.rk_valid;
    while (!bus_if.keys_valid && cyc < 100) begin
      bus_if.rd_start = rd_during ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      cyc++;
      if (bus_if.rk_valid) saw_rk = 1'b1;
    end
    bus_if.rd_start = 1'b0;
    check({tag, " keys_valid latency"}, 32'(cyc), 32'd33);
    check({tag, " no rk_valid during expand"}, 32'(saw_rk), 32'd0);
    check({tag, " key_ready in READY"}, 32'(bus_if.key_ready), 32'd1);
  endtask

  // mode 0: rk_ready always high; 1: 3-cycle stall on beat 5;
  // 2: random rk_ready plus key_valid/rd_start noise that must be ignored.
  task automatic stream(input logic dir, input int mode, input string tag);
    int beats = 0;
    int cyc = 0;
    int stall = 0;
    bit rev;
    bit rdy;
    logic [31:0] exp_w;
`ifdef SM4_KEY_REV_EN
    rev = dir;
`else
    rev = 1'b0;
`endif
    @(negedge clk);
    bus_if.rd_start = 1'b1;
    bus_if.rd_dir   = dir;
    bus_if.rk_ready = 1'b0;
    @(negedge clk);
    bus_if.rd_start = 1'b0;
    while (beats < 32 && cyc < 300) begin
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) begin
        if (beats == 4 && stall < 3) begin rdy = 1'b0; stall++; end
        else rdy = 1'b1;
      end else rdy = 1'($urandom_range(0, 1));
      if (mode == 2 && beats < 31) begin
        bus_if.key_valid = 1'($urandom_range(0, 1));
        bus_if.rd_start  = 1'($urandom_range(0, 1));
      end else begin
        bus_if.key_valid = 1'b0;
        bus_if.rd_start  = 1'b0;
      end
      bus_if.rk_ready = rdy;
      exp_w = exp_rk[rev ? 31 - beats : beats];
      check({tag, " rk_valid"}, 32'(bus_if.rk_valid), 32'd1);
      check({tag, " rk"},       bus_if.rk,            exp_w);
      check({tag, " rk_last"},  32'(bus_if.rk_last),  32'(beats == 31));
      if (rdy) begin
        if (beats == 0)  first_rk = bus_if.rk;
        if (beats == 31) last_rk  = bus_if.rk;
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    bus_if.rk_ready  = 1'b0;
    bus_if.key_valid = 1'b0;
    bus_if.rd_start  = 1'b0;
    check({tag, " beat count"},      32'(beats),              32'd32);
    check({tag, " rk_valid after"},  32'(bus_if.rk_valid),    32'd0);
    check({tag, " rk_last after"},   32'(bus_if.rk_last),     32'd0);
    check({tag, " key_ready after"}, 32'(bus_if.key_ready),   32'd1);
    check({tag, " keys_valid after"},32'(bus_if.keys_valid),  32'd1);
  endtask

  // ---------------- main sequence ----------------
  localparam logic [0:127] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

  initial begin
    bit saw_kv;
    logic [0:127] rkey;
    bit rev_on;
`ifdef SM4_KEY_REV_EN
    rev_on = 1'b1;
`else
    rev_on = 1'b0;
`endif
    rst              = 1'b1;
    bus_if.mk        = '0;
    bus_if.key_valid = 1'b0;
    bus_if.rd_start  = 1'b0;
    bus_if.rd_dir    = 1'b0;
    bus_if.rk_ready  = 1'b0;
    repeat (3) @(negedge clk);
    reset_values("reset");
    rst = 1'b0;

    // Standard vector, forward then reverse, then backpressure.
    load_key(STD_KEY, 1'b0, 1'b0, "std");
    stream(1'b0, 0, "std fwd");
    check("std rk0 first", first_rk, 32'hF12186F9);
    check("std rk31 last", last_rk,  32'h9124A012);
    stream(1'b1, 0, "std rev");
    check("rev first beat", first_rk, rev_on ? 32'h9124A012 : 32'hF12186F9);
    check("rev last beat",  last_rk,  rev_on ? 32'hF12186F9 : 32'h9124A012);
    stream(1'b0, 1, "backpressure");

    // Random keys with random backpressure and ignored requests in STREAM.
    for (int n = 0; n < 3; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      load_key(rkey, 1'b0, 1'b0, "rand");
      stream(1'($urandom_range(0, 1)), 2, "rand stream");
    end

    // Rekey from READY with rd_start toggling through the expansion.
    rkey = {$urandom, $urandom, $urandom, $urandom};
    load_key(rkey, 1'b0, 1'b1, "rekey");
    stream(1'b0, 0, "rekey stream");

    // rd_start together with key_valid in READY: key wins.
    rkey = {$urandom, $urandom, $urandom, $urandom};
    load_key(rkey, 1'b1, 1'b0, "simul");
    stream(1'b1, 2, "simul stream");

    // Reset at round 10 of expansion.
    @(negedge clk);
    bus_if.mk        = STD_KEY;
    bus_if.key_valid = 1'b1;
    @(negedge clk);
    bus_if.key_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_values("rst expand");
    saw_kv = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.keys_valid) saw_kv = 1'b1;
    end
    check("rst expand keys_valid stays low", 32'(saw_kv), 32'd0);

    // Reset mid-stream.
    rkey = {$urandom, $urandom, $urandom, $urandom};
    load_key(rkey, 1'b0, 1'b0, "pre rst");
    @(negedge clk);
    bus_if.rd_start = 1'b1;
    bus_if.rd_dir   = 1'b0;
    bus_if.rk_ready = 1'b1;
    @(negedge clk);
    bus_if.rd_start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre rst rk", bus_if.rk, exp_rk[5]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_if.rk_ready = 1'b0;
    reset_values("rst stream");

    // Recovery after reset.
    load_key(STD_KEY, 1'b0, 1'b0, "recover");
    stream(1'b0, 0, "recover stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
